vga_timing_gen: RTL and testbench

Parametrised VGA raster engine that replaces the fixed 640x480 driver used by the lab controllers. It generates horizontal and vertical timing from parameters and issues pixel coordinates ahead of display. A configurable delay line aligns the returned `color_in` with sync and blank, so pixel sources with multi-cycle read latency (ROM, framebuffer RAM) can be used. It expands RRRGGGBB colour to 8-bit DAC channels and drives the ADV7123-style VGA pins directly from registers.

---
 rtl/vga_timing_gen.sv | 200 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster engine. Issues pixel coordinates ahead of
//            display and realigns returned colour with sync/blank on the pins.
//            Optional colour-bar generator guarded by VGA_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_LAT  = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       vga_pll,
    input  logic       vga_reset_n,
    input  logic [7:0] color_in,
    input  logic       test_mode,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       pixel_req,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int          c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last   = 10'(c_v_total - 1);
    // Compare constants carry an extra bit so a sync region ending at 1024 still fits.
    localparam logic [10:0] c_h_act    = 11'(H_ACTIVE);
    localparam logic [10:0] c_hs_beg   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_v_act    = 11'(V_ACTIVE);
    localparam logic [10:0] c_vs_beg   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic [9:0]       r_next_x;
    logic [9:0]       r_next_y;
    logic             r_frame_start;
    logic [PIX_LAT:0] r_hs_d;
    logic [PIX_LAT:0] r_vs_d;
    logic [PIX_LAT:0] r_act_d;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic [7:0]       r_r;
    logic [7:0]       r_g;
    logic [7:0]       r_b;

    logic [10:0]      w_h;
    logic [10:0]      w_v;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_hs;
    logic             w_vs;
    logic [7:0]       w_color;

    assign w_h     = {1'b0, r_h_cnt};
    assign w_v     = {1'b0, r_v_cnt};
    assign w_h_act = (w_h < c_h_act);
    assign w_v_act = (w_v < c_v_act);
    assign w_hs    = (w_h >= c_hs_beg) && (w_h < c_hs_end);
    assign w_vs    = (w_v >= c_vs_beg) && (w_v < c_vs_end);

    always_ff @(posedge vga_pll) begin
        if (!vga_reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage 0 of the delay line is the issue stage itself, so the tap at
    // PIX_LAT lines up with the colour returned for that coordinate.
    always_ff @(posedge vga_pll) begin
        if (!vga_reset_n) begin
            r_next_x      <= '0;
            r_next_y      <= '0;
            r_frame_start <= 1'b0;
            r_hs_d        <= '0;
            r_vs_d        <= '0;
            r_act_d       <= '0;
        end else begin
            r_next_x      <= w_h_act ? r_h_cnt : 10'd0;
            r_next_y      <= w_v_act ? r_v_cnt : 10'd0;
            r_frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
            r_hs_d[0]     <= w_hs;
            r_vs_d[0]     <= w_vs;
            r_act_d[0]    <= w_h_act && w_v_act;
            for (int i = 1; i <= PIX_LAT; i++) begin
                r_hs_d[i]  <= r_hs_d[i-1];
                r_vs_d[i]  <= r_vs_d[i-1];
                r_act_d[i] <= r_act_d[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_bar_w = H_ACTIVE / 8;

    logic [9:0] r_x_d [0:PIX_LAT];
    logic [2:0] w_bar_idx;
    logic [7:0] w_bar_col;

    always_ff @(posedge vga_pll) begin
        if (!vga_reset_n) begin
            for (int i = 0; i <= PIX_LAT; i++) r_x_d[i] <= '0;
        end else begin
            r_x_d[0] <= w_h_act ? r_h_cnt : 10'd0;
            for (int i = 1; i <= PIX_LAT; i++) r_x_d[i] <= r_x_d[i-1];
        end
    end

    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_x_d[PIX_LAT] >= 10'(k * c_bar_w)) w_bar_idx = 3'(k);
        end
    end

    always_comb begin
        w_bar_col = 8'h00;
        case (w_bar_idx)
            3'd0:    w_bar_col = 8'hFF;
            3'd1:    w_bar_col = 8'hFC;
            3'd2:    w_bar_col = 8'h1F;
            3'd3:    w_bar_col = 8'h1C;
            3'd4:    w_bar_col = 8'hE3;
            3'd5:    w_bar_col = 8'hE0;
            3'd6:    w_bar_col = 8'h03;
            default: w_bar_col = 8'h00;
        endcase
    end

    assign w_color = test_mode ? w_bar_col : color_in;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_color            = color_in;
`endif

    always_ff @(posedge vga_pll) begin
        if (!vga_reset_n) begin
            r_hs      <= !SYNC_POL;
            r_vs      <= !SYNC_POL;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else begin
            r_hs      <= r_hs_d[PIX_LAT] ? SYNC_POL : !SYNC_POL;
            r_vs      <= r_vs_d[PIX_LAT] ? SYNC_POL : !SYNC_POL;
            r_blank_n <= r_act_d[PIX_LAT];
            if (r_act_d[PIX_LAT]) begin
                r_r <= {w_color[7:5], w_color[7:5], w_color[7:6]};
                r_g <= {w_color[4:2], w_color[4:2], w_color[4:3]};
                r_b <= {4{w_color[1:0]}};
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign next_x      = r_next_x;
    assign next_y      = r_next_y;
    assign pixel_req   = r_act_d[0];
    assign frame_start = r_frame_start;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_pll;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed self-checking bench for vga_timing_gen on a small
//            12x7 raster with PIX_LAT=3 and active-high syncs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int H_ACT  = 8;
    localparam int H_FP   = 1;
    localparam int H_SYNC = 2;
    localparam int H_BP   = 1;
    localparam int V_ACT  = 4;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 1;
    localparam int V_BP   = 1;
    localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int LAT    = 3;
    localparam bit POL    = 1'b1;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] color_in  = 8'h00;
    logic       test_mode = 1'b0;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       pixel_req;
    logic       frame_start;
    logic       vga_hs;
    logic       vga_vs;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       vga_clk;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (H_ACT),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_LAT  (LAT),
        .SYNC_POL (POL)
    ) dut (
        .vga_pll     (clk),
        .vga_reset_n (rst_n),
        .color_in    (color_in),
        .test_mode   (test_mode),
        .next_x      (next_x),
        .next_y      (next_y),
        .pixel_req   (pixel_req),
        .frame_start (frame_start),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_BLANK_N (vga_blank_n),
        .VGA_SYNC_N  (vga_sync_n),
        .VGA_CLK     (vga_clk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hx(input int m);
        return m % H_TOT;
    endfunction

    function automatic int vy(input int m);
        return (m / H_TOT) % V_TOT;
    endfunction

    function automatic bit act(input int m);
        return (hx(m) < H_ACT) && (vy(m) < V_ACT);
    endfunction

    // Colour returned for the coordinate issued at cycle m; garbage where it must be ignored.
    function automatic logic [7:0] src_col(input int mode, input int m);
        if (m < 0) return 8'hFF;
        case (mode)
            0:       return act(m) ? 8'(hx(m) * 37 + vy(m) * 91 + 5) : 8'hFF;
            1:       return 8'hFF;
            default: return 8'h25;
        endcase
    endfunction

    function automatic logic [7:0] exp_col(input int mode, input int m);
        logic [7:0] bars [0:7];
        bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
`ifdef VGA_TEST_PATTERN_EN
        if (mode == 2) return bars[hx(m)];
`else
        if (mode == 99) return bars[0];
`endif
        return src_col(mode, m);
    endfunction

    task automatic check_idle(input string p);
        check({p, "_next_x"},  32'(next_x),      32'h0);
        check({p, "_next_y"},  32'(next_y),      32'h0);
        check({p, "_req"},     32'(pixel_req),   32'h0);
        check({p, "_fstart"},  32'(frame_start), 32'h0);
        check({p, "_hs"},      32'(vga_hs),      32'h0);
        check({p, "_vs"},      32'(vga_vs),      32'h0);
        check({p, "_blank_n"}, 32'(vga_blank_n), 32'h0);
        check({p, "_r"},       32'(vga_r),       32'h0);
        check({p, "_g"},       32'(vga_g),       32'h0);
        check({p, "_b"},       32'(vga_b),       32'h0);
        check({p, "_sync_n"},  32'(vga_sync_n),  32'h0);
        check({p, "_clk"},     32'(vga_clk),     32'(clk));
    endtask

    // Cycle n counts from the first edge after release; coordinate n is issued then.
    task automatic run(input int ncyc, input int mode);
        for (int n = 0; n < ncyc; n++) begin
            int         m;
            bit         hs_on;
            bit         vs_on;
            bit         a;
            logic [7:0] c;
            @(posedge clk);
            #1;
            color_in = src_col(mode, n - LAT);
            @(negedge clk);
            check($sformatf("next_x@%0d", n), 32'(next_x), (hx(n) < H_ACT) ? hx(n) : 0);
            check($sformatf("next_y@%0d", n), 32'(next_y), (vy(n) < V_ACT) ? vy(n) : 0);
            check($sformatf("req@%0d", n), 32'(pixel_req), 32'(act(n)));
            check($sformatf("fstart@%0d", n), 32'(frame_start),
                  32'((hx(n) == 0) && (vy(n) == 0)));
            m = n - LAT - 1;
            if (m < 0) begin
                hs_on = 1'b0;
                vs_on = 1'b0;
                a     = 1'b0;
                c     = 8'h00;
            end else begin
                hs_on = (hx(m) >= H_ACT + H_FP) && (hx(m) < H_ACT + H_FP + H_SYNC);
                vs_on = (vy(m) >= V_ACT + V_FP) && (vy(m) < V_ACT + V_FP + V_SYNC);
                a     = act(m);
                c     = exp_col(mode, m);
            end
            check($sformatf("hs@%0d", n), 32'(vga_hs), 32'(hs_on ? POL : !POL));
            check($sformatf("vs@%0d", n), 32'(vga_vs), 32'(vs_on ? POL : !POL));
            check($sformatf("blank_n@%0d", n), 32'(vga_blank_n), 32'(a));
            check($sformatf("r@%0d", n), 32'(vga_r), a ? 32'({c[7:5], c[7:5], c[7:6]}) : 32'h0);
            check($sformatf("g@%0d", n), 32'(vga_g), a ? 32'({c[4:2], c[4:2], c[4:3]}) : 32'h0);
            check($sformatf("b@%0d", n), 32'(vga_b), a ? 32'({4{c[1:0]}}) : 32'h0);
        end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle("rst");

        // Two full frames plus a line: exercises line wrap, frame wrap and frame_start repeat.
        rst_n = 1'b1;
        run(2 * H_TOT * V_TOT + H_TOT, 0);

        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst2");

        // Stop with the pins inside both sync pulses, then reset mid-frame.
        rst_n = 1'b1;
        run(74, 1);
        check("pre_mid_hs", 32'(vga_hs), 32'h1);
        check("pre_mid_vs", 32'(vga_vs), 32'h1);
        check("pre_mid_blank_n", 32'(vga_blank_n), 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("mid");

        rst_n     = 1'b1;
        test_mode = 1'b1;
        run(90, 2);
        // Last cycle shows the pixel issued for (1,0) of the second frame.
`ifdef VGA_TEST_PATTERN_EN
        check("final_r", 32'(vga_r), 32'hFF);
        check("final_g", 32'(vga_g), 32'hFF);
        check("final_b", 32'(vga_b), 32'h00);
`else
        check("final_r", 32'(vga_r), 32'h24);
        check("final_g", 32'(vga_g), 32'h24);
        check("final_b", 32'(vga_b), 32'h55);
`endif
        check("final_blank_n", 32'(vga_blank_n), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
